// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the multiply/divide unit.
//   mdu_op_t    - op field encoding shared with the main decoder
//   mdu_state_t - MDU sequencer states
//   neg_if      - conditional two's-complement negation used for sign correction
package mdu_pkg;

    localparam int MDU_XLEN = 32;
    localparam int MDU_W2   = 2 * MDU_XLEN;

    typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;
    typedef enum logic [1:0] {IDLE, MUL, DIV} mdu_state_t;

    function automatic logic [MDU_W2-1:0] neg_if(input logic [MDU_W2-1:0] value, input logic cond);
        return cond ? -value : value;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit holding the HI/LO registers.
//   clk, reset_n      - clock, asynchronous active-low reset
//   start, op         - launch mult/multu/div/divu (op sampled with start, only when idle)
//   src1, src2        - multiplicand/dividend, multiplier/divisor; src1 is also the mthi/mtlo data
//   hi_we, lo_we      - mthi/mtlo write strobes, honoured only when idle and start is low
//   hi, lo            - architectural HI/LO registers
//   busy, done        - operation in progress / one-cycle completion pulse
// N may not exceed MDU_XLEN, the width neg_if is built for.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int N = MDU_XLEN
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic         hi_we,
    input  logic         lo_we,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N) + 1;

    mdu_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_a;
    logic [2*N-1:0]  r_acc;
    logic [N:0]      r_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [N-1:0]    r_hi;
    logic [N-1:0]    r_lo;
    logic            r_busy;
    logic            r_done;

    logic            w_s1;
    logic            w_s2;
    logic [N-1:0]    w_mag1;
    logic [N-1:0]    w_mag2;
    logic [N:0]      w_sum;
    logic [2*N-1:0]  w_prod;
    logic [N:0]      w_rsh;
    logic            w_ge;
    logic [N:0]      w_rem;
    logic [N-1:0]    w_quo;
    logic            w_last;
    logic [MDU_W2-1:0] w_prod_c;
    logic [MDU_W2-1:0] w_quo_c;
    logic [MDU_W2-1:0] w_rem_c;
    logic            w_unused;

    assign w_s1   = ~op[0] & src1[N-1];
    assign w_s2   = ~op[0] & src2[N-1];
    assign w_mag1 = w_s1 ? -src1 : src1;
    assign w_mag2 = w_s2 ? -src2 : src2;

    // Multiply: multiplier sits in acc's low half and shifts out as the product shifts in.
    assign w_sum  = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_acc[0] ? r_a : '0};
    assign w_prod = {w_sum, r_acc[N-1:1]};

    // Divide: dividend shifts out of acc's low half, quotient bits shift in behind it.
    assign w_rsh  = {r_rem[N-1:0], r_acc[N-1]};
    assign w_ge   = w_rsh >= {1'b0, r_a};
    assign w_rem  = w_ge ? w_rsh - {1'b0, r_a} : w_rsh;
    assign w_quo  = {r_acc[N-2:0], w_ge};

    assign w_last   = r_cnt == CW'(N - 1);
    assign w_prod_c = neg_if(MDU_W2'(w_prod), r_neg_q);
    assign w_quo_c  = neg_if(MDU_W2'(w_quo), r_neg_q);
    assign w_rem_c  = neg_if(MDU_W2'(w_rem[N-1:0]), r_neg_r);
    assign w_unused = ^{w_quo_c, w_rem_c, w_prod_c, w_rem[N], r_rem[N]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= op[1] ? DIV : MUL;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        // A zero divisor keeps the quotient all ones and the remainder equal to src1.
                        r_neg_q <= (w_s1 ^ w_s2) & (|src2);
                        r_neg_r <= w_s1;
                        r_a     <= op[1] ? w_mag2 : w_mag1;
                        r_acc   <= {{N{1'b0}}, op[1] ? w_mag1 : w_mag2};
                    end else begin
                        if (hi_we) r_hi <= src1;
                        if (lo_we) r_lo <= src1;
                    end
                end
                MUL: begin
                    r_acc <= w_prod;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi    <= w_prod_c[2*N-1:N];
                        r_lo    <= w_prod_c[N-1:0];
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DIV: begin
                    r_rem          <= w_rem;
                    r_acc[N-1:0]   <= w_quo;
                    r_cnt          <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi    <= w_rem_c[N-1:0];
                        r_lo    <= w_quo_c[N-1:0];
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [N-1:0] src1 = '0;
    logic [N-1:0] src2 = '0;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;

    int           total = 0;
    int           bad = 0;
    logic [N-1:0] m_hi = '0;
    logic [N-1:0] m_lo = '0;
    logic [N-1:0] e_hi;
    logic [N-1:0] e_lo;
    logic         saw_done;

    always #5 clk = ~clk;

    mult_div_unit #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src1(src1), .src2(src2), .hi_we(hi_we), .lo_we(lo_we),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'd0) return 64'(sa * sb);
        if (o == 2'd1) return 64'(a) * 64'(b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic we);
        {e_hi, e_lo} = model(o, a, b);
        op = o;
        src1 = a;
        src2 = b;
        start = 1'b1;
        hi_we = we;
        lo_we = we;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish(input string tag, input int skip);
        repeat (N - 1 - skip) @(posedge clk);
        #1;
        check({tag, "_busy_mid"}, 32'(busy), 32'd1);
        check({tag, "_hi_hold"}, hi, m_hi);
        check({tag, "_lo_hold"}, lo, m_lo);
        @(posedge clk);
        #1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, e_hi);
        check({tag, "_lo"}, lo, e_lo);
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic rnd_launch();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        o = 2'($urandom_range(0, 3));
        a = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
        sel = $urandom_range(0, 5);
        b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
            (sel == 2) ? 32'hFFFF_FFFF : $urandom;
        launch(o, a, b, 1'b0);
    endtask

    initial begin
        #2;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish("multu_max", 0);
        idle();
        launch(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        finish("mult_neg", 0);
        idle();
        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        finish("div_neg", 0);
        idle();
        launch(MDU_DIVU, 32'd7, 32'd0, 1'b0);
        finish("divu_zero", 0);
        idle();
        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
        finish("div_zero_neg", 0);
        idle();
        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        finish("div_ovf", 0);
        idle();

        launch(MDU_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        op = MDU_MULT;
        src1 = 32'd99;
        src2 = 32'd99;
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        finish("busy_ignore", 5);
        launch(MDU_MULTU, 32'd3, 32'd4, 1'b0);
        finish("back_to_back", 0);
        idle();

        src1 = 32'h0000_1234;
        hi_we = 1'b1;
        lo_we = 1'b1;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi", hi, 32'h0000_1234);
        check("mtlo", lo, 32'h0000_1234);
        check("mt_no_done", 32'(done), 32'd0);
        m_hi = 32'h0000_1234;
        m_lo = 32'h0000_1234;
        launch(MDU_MULTU, 32'd6, 32'd7, 1'b1);
        finish("start_over_mt", 0);
        idle();

        launch(MDU_MULT, 32'd12345, 32'hFFFF_FFF7, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (N + 3) begin
            @(posedge clk);
            #1;
            saw_done = saw_done | done | busy;
        end
        check("midrst_quiet", 32'(saw_done), 32'd0);

        rnd_launch();
        for (int i = 0; i < 24; i++) begin
            finish("rnd", 0);
            if (i % 4 == 3) idle();
            rnd_launch();
        end
        finish("rnd_last", 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
